// File: rtl/fb_port_arbiter.sv
// Shares the single-port framebuffer BRAM between the display scan-out reader and the host.
// Display has fixed priority; the host is guaranteed a slot after STARVE_MAX denied cycles.
module fb_port_arbiter #(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FB_DEPTH   = 76800,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_err,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [15:0]       disp_miss_cnt,
  output logic [15:0]       host_err_cnt
);

  localparam logic [ADDR_W:0] LP_DEPTH  = (ADDR_W + 1)'(FB_DEPTH);
  localparam logic [7:0]      LP_STARVE = 8'(STARVE_MAX);

  logic [7:0]        r_wait_cnt;
  logic [RD_LAT:0]   r_tag_vld;
  logic [RD_LAT:0]   r_tag_host;
  logic              r_disp_rvalid, r_host_rvalid, r_host_err;
  logic [DATA_W-1:0] r_disp_rdata, r_host_rdata;
  logic              r_bram_en, r_bram_we;
  logic [ADDR_W-1:0] r_bram_addr;
  logic [DATA_W-1:0] r_bram_din;
  logic [15:0]       r_disp_miss_cnt, r_host_err_cnt;

  logic w_disp_gnt, w_host_gnt;
  logic w_disp_acc, w_host_acc, w_host_oor, w_host_bram, w_host_rd, w_rd, w_disp_miss;

  always_comb begin
    w_disp_gnt = 1'b0;
    w_host_gnt = 1'b0;
    if (!RESET) begin
      if (disp_req && host_req) begin
        if (r_wait_cnt < LP_STARVE) w_disp_gnt = 1'b1;
        else                        w_host_gnt = 1'b1;
      end else begin
        w_disp_gnt = disp_req;
        w_host_gnt = host_req;
      end
    end
  end

  assign w_disp_acc  = disp_req & w_disp_gnt;
  assign w_host_acc  = host_req & w_host_gnt;
  assign w_host_oor  = {1'b0, host_addr} >= LP_DEPTH;
  assign w_host_bram = w_host_acc & ~w_host_oor;
  assign w_host_rd   = w_host_bram & ~host_we;
  assign w_rd        = w_disp_acc | w_host_rd;
  assign w_disp_miss = disp_req & ~w_disp_gnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wait_cnt      <= '0;
      r_tag_vld       <= '0;
      r_tag_host      <= '0;
      r_disp_rvalid   <= 1'b0;
      r_host_rvalid   <= 1'b0;
      r_disp_rdata    <= '0;
      r_host_rdata    <= '0;
      r_host_err      <= 1'b0;
      r_bram_en       <= 1'b0;
      r_bram_we       <= 1'b0;
      r_bram_addr     <= '0;
      r_bram_din      <= '0;
      r_disp_miss_cnt <= '0;
      r_host_err_cnt  <= '0;
    end else begin
      if (!host_req || w_host_acc) r_wait_cnt <= '0;
      else if (w_disp_acc)         r_wait_cnt <= r_wait_cnt + 8'd1;

      r_bram_en <= w_disp_acc | w_host_bram;
      r_bram_we <= w_host_bram & host_we;
      if (w_disp_acc) begin
        r_bram_addr <= disp_addr;
      end else if (w_host_bram) begin
        r_bram_addr <= host_addr;
        r_bram_din  <= host_wdata;
      end

      r_host_err <= w_host_acc & w_host_oor;
      if (w_host_acc && w_host_oor && r_host_err_cnt != 16'hFFFF)
        r_host_err_cnt <= r_host_err_cnt + 16'd1;
      if (w_disp_miss && r_disp_miss_cnt != 16'hFFFF)
        r_disp_miss_cnt <= r_disp_miss_cnt + 16'd1;

      // Stage RD_LAT lines up with bram_dout for the read issued RD_LAT+1 edges earlier.
      r_tag_vld  <= {r_tag_vld[RD_LAT-1:0], w_rd};
      r_tag_host <= {r_tag_host[RD_LAT-1:0], w_host_rd};

      r_disp_rvalid <= r_tag_vld[RD_LAT] & ~r_tag_host[RD_LAT];
      r_host_rvalid <= r_tag_vld[RD_LAT] & r_tag_host[RD_LAT];
      if (r_tag_vld[RD_LAT] && !r_tag_host[RD_LAT]) r_disp_rdata <= bram_dout;
      if (r_tag_vld[RD_LAT] && r_tag_host[RD_LAT])  r_host_rdata <= bram_dout;
    end
  end

  assign disp_gnt      = w_disp_gnt;
  assign host_gnt      = w_host_gnt;
  assign disp_rvalid   = r_disp_rvalid;
  assign disp_rdata    = r_disp_rdata;
  assign host_rvalid   = r_host_rvalid;
  assign host_rdata    = r_host_rdata;
  assign host_err      = r_host_err;
  assign bram_en       = r_bram_en;
  assign bram_we       = r_bram_we;
  assign bram_addr     = r_bram_addr;
  assign bram_din      = r_bram_din;
  assign disp_miss_cnt = r_disp_miss_cnt;
  assign host_err_cnt  = r_host_err_cnt;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: BRAM model, shadow memory and read-return scoreboard queues.
module tb_fb_port_arbiter;

  localparam int FB_DEPTH = 76800;
  localparam int RD_LAT   = 1;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        disp_req, disp_gnt, disp_rvalid;
  logic [16:0] disp_addr;
  logic [15:0] disp_rdata;
  logic        host_req, host_we, host_gnt, host_rvalid, host_err;
  logic [16:0] host_addr;
  logic [15:0] host_wdata, host_rdata;
  logic        bram_en, bram_we;
  logic [16:0] bram_addr;
  logic [15:0] bram_din, bram_dout;
  logic [15:0] disp_miss_cnt, host_err_cnt;

  fb_port_arbiter #(
    .ADDR_W(17), .DATA_W(16), .FB_DEPTH(FB_DEPTH), .RD_LAT(RD_LAT), .STARVE_MAX(8)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_err(host_err),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_dout(bram_dout),
    .disp_miss_cnt(disp_miss_cnt), .host_err_cnt(host_err_cnt)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Single-port BRAM, one cycle read latency.
  logic [15:0] mem   [0:131071];
  logic [15:0] m_mem [0:131071];
  always @(posedge CLK) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      else         bram_dout <= mem[bram_addr];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } rd_t;

  rd_t         q_disp[$];
  rd_t         q_host[$];
  bit          exp_err, exp_en, exp_we;
  logic [16:0] exp_addr;
  int          n_disp_rv = 0;
  int          n_host_rv = 0;

  // Monitor: check last cycle's predictions, then record this cycle's acceptances.
  always @(negedge CLK) begin
    rd_t e;
    if (RESET) begin
      q_disp.delete();
      q_host.delete();
      exp_err = 1'b0;
      exp_en  = 1'b0;
      exp_we  = 1'b0;
    end else begin
      check_val("bram_cmd", 64'({bram_en, bram_we}), 64'({exp_en, exp_we}));
      if (exp_en) check_val("bram_addr", 64'(bram_addr), 64'(exp_addr));
      check_val("host_err", 64'(host_err), 64'(exp_err));
      if (disp_rvalid) begin
        n_disp_rv++;
        if (q_disp.size() == 0) begin
          check_val("disp_rv_spurious", 64'(1), 64'(0));
        end else begin
          e = q_disp.pop_front();
          check_val("disp_rdata", 64'(disp_rdata), 64'(e.data));
          check_val("disp_rv_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (host_rvalid) begin
        n_host_rv++;
        if (q_host.size() == 0) begin
          check_val("host_rv_spurious", 64'(1), 64'(0));
        end else begin
          e = q_host.pop_front();
          check_val("host_rdata", 64'(host_rdata), 64'(e.data));
          check_val("host_rv_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      exp_err = 1'b0;
      exp_en  = 1'b0;
      exp_we  = 1'b0;
      if (disp_req && disp_gnt) begin
        q_disp.push_back('{data: m_mem[disp_addr], cyc: cyc + 2 + RD_LAT});
        exp_en   = 1'b1;
        exp_addr = disp_addr;
      end
      if (host_req && host_gnt) begin
        if (32'(host_addr) >= FB_DEPTH) begin
          exp_err = 1'b1;
        end else begin
          exp_en   = 1'b1;
          exp_we   = host_we;
          exp_addr = host_addr;
          if (host_we) m_mem[host_addr] = host_wdata;
          else q_host.push_back('{data: m_mem[host_addr], cyc: cyc + 2 + RD_LAT});
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic disp_rd(input logic [16:0] a);
    bit g;
    int n = 0;
    disp_req  = 1'b1;
    disp_addr = a;
    do begin
      @(negedge CLK);
      g = disp_gnt;
      step();
      n++;
    end while (!g && n < 50);
    if (!g) check_val("disp_gnt_timeout", 64'(0), 64'(1));
    disp_req = 1'b0;
  endtask

  task automatic host_op(input logic we, input logic [16:0] a, input logic [15:0] d);
    bit g;
    int n = 0;
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
    do begin
      @(negedge CLK);
      g = host_gnt;
      step();
      n++;
    end while (!g && n < 50);
    if (!g) check_val("host_gnt_timeout", 64'(0), 64'(1));
    host_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ctl"}, 64'({disp_gnt, host_gnt, disp_rvalid, host_rvalid, host_err,
                                  bram_en, bram_we}), 64'(0));
    check_val({tag, "_addr_din"}, 64'({bram_addr, bram_din}), 64'(0));
    check_val({tag, "_rdata"}, 64'({disp_rdata, host_rdata}), 64'(0));
    check_val({tag, "_cnts"}, 64'({disp_miss_cnt, host_err_cnt}), 64'(0));
  endtask

  // Both requesters held for n cycles; host wins exactly every ninth cycle.
  task automatic contend(input int n);
    disp_req  = 1'b1;
    disp_addr = 17'd7;
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 17'd200;
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      check_val("contend_host_gnt", 64'(host_gnt), 64'((k % 9) == 8));
      check_val("contend_disp_gnt", 64'(disp_gnt), 64'((k % 9) != 8));
      step();
    end
    disp_req = 1'b0;
    host_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, rv0, hrv0;
    logic [15:0] m0;
    for (int i = 0; i < 131072; i++) begin
      mem[i]   <= 16'(i);
      m_mem[i] = 16'(i);
    end
    RESET = 1'b1;
    disp_req = 1'b0; disp_addr = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) step();
    disp_req = 1'b1;
    host_req = 1'b1;
    @(negedge CLK);
    check_all_zero("reset");
    step();
    disp_req = 1'b0;
    host_req = 1'b0;
    RESET    = 1'b0;
    step();

    // Display-only stream of addresses 0..9, one grant per cycle.
    c0 = cyc;
    for (int i = 0; i < 10; i++) disp_rd(17'(i));
    check_val("disp_stream_cycles", 64'(cyc - c0), 64'(10));
    repeat (5) step();
    check_val("disp_stream_rv_count", 64'(n_disp_rv), 64'(10));

    // Host write then read back.
    rv0 = n_disp_rv;
    host_op(1'b1, 17'd100, 16'h1234);
    host_op(1'b0, 17'd100, 16'h0000);
    repeat (4) step();
    check_val("host_rd_count", 64'(n_host_rv), 64'(1));
    check_val("host_rd_data", 64'(host_rdata), 64'(16'h1234));
    check_val("host_no_disp_rv", 64'(n_disp_rv), 64'(rv0));

    // Contention: 36 cycles give four forced host slots.
    m0 = disp_miss_cnt;
    contend(36);
    check_val("contend_miss_delta", 64'(disp_miss_cnt - m0), 64'(4));
    repeat (5) step();

    // Out-of-range host read.
    hrv0 = n_host_rv;
    host_op(1'b0, 17'(FB_DEPTH), 16'h0000);
    @(negedge CLK);
    check_val("oor_err_pulse", 64'(host_err), 64'(1));
    check_val("oor_bram_en", 64'(bram_en), 64'(0));
    step();
    check_val("oor_err_cnt", 64'(host_err_cnt), 64'(1));
    repeat (4) step();
    check_val("oor_no_rvalid", 64'(n_host_rv), 64'(hrv0));

    // Reset one cycle after a display read is accepted.
    rv0 = n_disp_rv;
    disp_rd(17'd5);
    RESET = 1'b1;
    step();
    @(negedge CLK);
    check_all_zero("reset_mid");
    step();
    RESET = 1'b0;
    repeat (6) step();
    check_val("reset_mid_no_rv", 64'(n_disp_rv), 64'(rv0));

    // Saturation of both counters, preset close to the top.
    force dut.r_disp_miss_cnt = 16'hFFFD;
    force dut.r_host_err_cnt  = 16'hFFFE;
    step();
    release dut.r_disp_miss_cnt;
    release dut.r_host_err_cnt;
    contend(45);
    check_val("miss_saturate", 64'(disp_miss_cnt), 64'(16'hFFFF));
    host_op(1'b0, 17'h1FFFF, 16'h0000);
    host_op(1'b0, 17'(FB_DEPTH + 5), 16'h0000);
    step();
    check_val("err_saturate", 64'(host_err_cnt), 64'(16'hFFFF));
    check_val("miss_held", 64'(disp_miss_cnt), 64'(16'hFFFF));
    repeat (5) step();

    check_val("disp_queue_drained", 64'(q_disp.size()), 64'(0));
    check_val("host_queue_drained", 64'(q_host.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares the single-port framebuffer BRAM (17-bit address, 16-bit RGB565 word) between two requesters.
  - Display scan-out reader: read-only, latency-critical.
  - Host requester: read/write, from the AHB-side register/memory logic.
- Fixed priority to display, with a bounded-starvation guarantee for the host.
- Host addresses beyond the framebuffer depth are rejected.
- Read data is returned with fixed latency.
- Saturating counters report display stalls and host address errors.

Parameters:
- ADDR_W, 17, BRAM address width.
- DATA_W, 16, pixel word width.
- FB_DEPTH, 76800, valid words; host addresses >= FB_DEPTH are out of range.
- RD_LAT, 1, BRAM read latency in cycles (1..3).
- STARVE_MAX, 8, maximum consecutive denied host cycles before the host is forced a slot (2..255).

Ports:
- CLK  in  1  single clock, shared with BRAM.
- RESET  in  1  synchronous, active-high.
- disp_req  in  1  display read request.
- disp_addr  in  ADDR_W  display word address.
- disp_gnt  out  1  display request accepted this cycle.
- disp_rvalid  out  1  display read data valid.
- disp_rdata  out  DATA_W  display read data.
- host_req  in  1  host request.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host word address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  host request accepted this cycle.
- host_rvalid  out  1  host read data valid.
- host_rdata  out  DATA_W  host read data.
- host_err  out  1  one-cycle pulse: host request rejected (out of range).
- bram_en  out  1  BRAM enable (registered).
- bram_we  out  1  BRAM write enable (registered).
- bram_addr  out  ADDR_W  BRAM address (registered).
- bram_din  out  DATA_W  BRAM write data (registered).
- bram_dout  in  DATA_W  BRAM read data.
- disp_miss_cnt  out  16  saturating count of cycles disp_req was high and disp_gnt low.
- host_err_cnt  out  16  saturating count of host_err pulses.

Behaviour:
- Handshake:
  - A request is accepted on a rising edge where req && gnt.
  - The requester holds req, addr, we and wdata stable until accepted.
  - gnt is combinational from the req signals and the arbiter state.
  - At most one requester is granted per cycle.
- Arbitration (grant logic plus starvation counter `wait_cnt`, 8 bits):
  - Only disp_req: disp_gnt = 1.
  - Only host_req: host_gnt = 1.
  - Both requesting, wait_cnt < STARVE_MAX: disp_gnt = 1, host_gnt = 0, wait_cnt increments.
  - Both requesting, wait_cnt == STARVE_MAX: host_gnt = 1, disp_gnt = 0; that cycle counts as a display miss.
  - wait_cnt clears on any host acceptance, and whenever host_req is low.
- Range check:
  - Host request with host_addr >= FB_DEPTH: host_gnt = 1 (consumed), no BRAM access, host_err pulses in the cycle after acceptance, host_rvalid never asserts for it.
  - Out-of-range display addresses are not checked; they are forwarded as given.
- BRAM command:
  - Driven one cycle after acceptance: bram_en = 1 and bram_addr, bram_we, bram_din from the accepted request.
  - With no acceptance: bram_en = 0, bram_we = 0, address and data hold their previous values.
- Read return:
  - An owner-tag shift register of depth RD_LAT+1 tracks each read.
  - A read accepted at edge E returns rvalid = 1 with rdata = bram_dout in the cycle beginning at edge E+1+RD_LAT, to the owner only.
  - Writes produce no rvalid.
  - Back-to-back reads stream at one per cycle.
  - rdata of a non-owner holds its last value.
- Counters: disp_miss_cnt and host_err_cnt saturate at 0xFFFF and do not wrap.
- Reset:
  - All outputs are 0: gnt outputs are forced 0 while RESET is high; bram_en, bram_we, bram_addr, bram_din, rvalid, rdata, host_err and both counters are 0.
  - wait_cnt and the tag pipeline clear.
  - Reads in flight at reset are dropped; no rvalid appears after RESET deasserts.
- Simultaneous events:
  - A host_err pulse and a display rvalid in the same cycle are independent.
  - Saturation holds even when an increment condition is present.

Test Plan:
- Display only: disp_req held, addresses 0..9, BRAM preloaded with data = addr -> disp_gnt high every cycle; disp_rvalid streams 0..9 starting 2 cycles after the first acceptance (RD_LAT = 1).
- Host write then read: write 0x1234 to address 100, then read address 100 -> host_gnt on each request; one host_rvalid with 0x1234; disp_rvalid stays low.
- Contention, STARVE_MAX = 8: both requesters request continuously -> pattern of 8 display grants, 1 host grant, repeating; disp_miss_cnt increments once per 9 cycles.
- Out of range: host read at address 76800 -> host_gnt = 1; host_err pulses next cycle; bram_en stays 0; host_err_cnt = 1; no host_rvalid.
- Reset mid-read: RESET asserted one cycle after a display read is accepted -> no disp_rvalid after release; all outputs 0 during reset.
- Saturation: force 70000 display-miss cycles -> disp_miss_cnt = 0xFFFF and remains there.
